// File: rtl/snn_seq_ctrl.sv
// Sequencing controller for the SNN digit classifier: loads one image from UART RX
// into the input RAM, starts the core, and sends the ASCII result to UART TX.
module snn_seq_ctrl #(
  parameter int NUM_PIXELS = 784,
  parameter int ADDR_W     = 10,
  parameter int RX_TIMEOUT = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wdata,
  output logic              core_start,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic              core_done,
  input  logic [3:0]        core_digit,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_rdy,
  output logic [7:0]        led,
  output logic              busy,
  output logic              err
);

  localparam int                CNT_W     = $clog2(RX_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [CNT_W-1:0]  IDLE_LAST = CNT_W'(RX_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RX,
    S_START,
    S_COMPUTE,
    S_TX
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [CNT_W-1:0]  r_idle_cnt;
  logic              r_ram_we;
  logic              r_ram_wdata;
  logic              r_core_start;
  logic              r_busy;
  logic              r_err;
  logic [7:0]        r_result;
  logic              w_tx_fire;

  // NOTE: tx_start and the compute-phase RAM address are combinational on purpose:
  // both must respond in the same cycle as tx_rdy / core_addr.
  assign w_tx_fire  = (r_state == S_TX) && tx_rdy;
  assign tx_start   = w_tx_fire;
  assign ram_addr   = (r_state == S_COMPUTE) ? core_addr : r_ram_addr;
  assign ram_we     = r_ram_we;
  assign ram_wdata  = r_ram_wdata;
  assign core_start = r_core_start;
  assign tx_data    = r_result;
  assign led        = r_result;
  assign busy       = r_busy;
  assign err        = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_RX;
      r_wr_addr    <= '0;
      r_ram_addr   <= '0;
      r_idle_cnt   <= '0;
      r_ram_we     <= 1'b0;
      r_ram_wdata  <= 1'b0;
      r_core_start <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      r_result     <= 8'h00;
    end else begin
      // NOTE: pulse outputs default low each cycle; every state assignment here is
      // non-blocking so all registers see the same pre-edge values.
      r_ram_we     <= 1'b0;
      r_core_start <= 1'b0;

      case (r_state)
        S_RX: begin
          if (rx_rdy) begin
            r_ram_we    <= 1'b1;
            r_ram_addr  <= r_wr_addr;
            r_ram_wdata <= rx_data[0];
            r_idle_cnt  <= '0;
            if (r_wr_addr == LAST_ADDR) begin
              r_wr_addr <= '0;
              r_state   <= S_START;
            end else begin
              r_wr_addr <= r_wr_addr + 1'b1;
            end
          end else if (r_wr_addr != '0) begin
            // A stalled partial frame is dropped so the next byte is pixel 0.
            if (r_idle_cnt == IDLE_LAST) begin
              r_wr_addr  <= '0;
              r_idle_cnt <= '0;
              r_err      <= 1'b1;
            end else begin
              r_idle_cnt <= r_idle_cnt + 1'b1;
            end
          end
        end

        S_START: begin
          r_core_start <= 1'b1;
          r_busy       <= 1'b1;
          r_state      <= S_COMPUTE;
        end

        S_COMPUTE: begin
          if (core_done) begin
            if (core_digit <= 4'd9) begin
              r_result <= 8'h30 + {4'h0, core_digit};
            end else begin
              r_result <= 8'h3F;
              r_err    <= 1'b1;
            end
            r_state <= S_TX;
          end
        end

        S_TX: begin
          if (w_tx_fire) begin
            r_busy  <= 1'b0;
            r_state <= S_RX;
          end
        end

        default: r_state <= S_RX;
      endcase

      // Bytes arriving while the image is being processed are lost.
      if (rx_rdy && (r_state != S_RX)) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_snn_seq_ctrl.sv
// Self-checking bench for snn_seq_ctrl: a frame-level reference model checked every
// cycle, plus directed literal checks on the key timing points.
module tb_snn_seq_ctrl;

  localparam int NP = 784;
  localparam int AW = 10;
  localparam int TO = 1000;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b0;
  logic          rx_rdy     = 1'b0;
  logic [7:0]    rx_data    = 8'h00;
  logic [AW-1:0] core_addr  = '0;
  logic          core_done  = 1'b0;
  logic [3:0]    core_digit = 4'h0;
  logic          tx_rdy     = 1'b0;

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic          ram_wdata;
  logic          core_start;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic [7:0]    led;
  logic          busy;
  logic          err;

  snn_seq_ctrl #(
    .NUM_PIXELS (NP),
    .ADDR_W     (AW),
    .RX_TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .core_start (core_start),
    .core_addr  (core_addr),
    .core_done  (core_done),
    .core_digit (core_digit),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_rdy     (tx_rdy),
    .led        (led),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model (frame-level phases) ----------------
  typedef enum {M_FILL, M_LAUNCH, M_CORE, M_REPLY} mphase_t;

  mphase_t       m_ph    = M_FILL;
  int            m_pix   = 0;
  int            m_idle  = 0;
  int            m_waddr = 0;
  bit            m_wbit  = 1'b0;
  bit            m_we    = 1'b0;
  bit            m_cs    = 1'b0;
  bit            m_busy  = 1'b0;
  bit            m_err   = 1'b0;
  logic [7:0]    m_char  = 8'h00;

  function automatic logic [7:0] ascii_of(input logic [3:0] d);
    int v;
    v = int'(d);
    return (v <= 9) ? 8'(48 + v) : 8'h3F;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_ph = M_FILL; m_pix = 0; m_idle = 0; m_waddr = 0; m_wbit = 1'b0;
      m_we = 1'b0; m_cs = 1'b0; m_busy = 1'b0; m_err = 1'b0; m_char = 8'h00;
    end else begin
      m_we = 1'b0;
      m_cs = 1'b0;
      if (rx_rdy && m_ph != M_FILL) m_err = 1'b1;
      case (m_ph)
        M_FILL: begin
          if (rx_rdy) begin
            m_we = 1'b1; m_waddr = m_pix; m_wbit = rx_data[0]; m_idle = 0;
            m_pix++;
            if (m_pix == NP) begin m_pix = 0; m_ph = M_LAUNCH; end
          end else if (m_pix > 0) begin
            m_idle++;
            if (m_idle == TO) begin m_pix = 0; m_idle = 0; m_err = 1'b1; end
          end
        end
        M_LAUNCH: begin m_cs = 1'b1; m_busy = 1'b1; m_ph = M_CORE; end
        M_CORE: begin
          if (core_done) begin
            m_char = ascii_of(core_digit);
            if (core_digit > 4'd9) m_err = 1'b1;
            m_ph = M_REPLY;
          end
        end
        M_REPLY: begin
          if (tx_rdy) begin m_busy = 1'b0; m_ph = M_FILL; end
        end
        default: m_ph = M_FILL;
      endcase
    end
  end

  // Per-cycle compare away from the active edge.
  initial forever begin
    logic [AW-1:0] e_addr;
    logic          e_txs;
    @(negedge clk);
    e_addr = (m_ph == M_CORE) ? core_addr : AW'(m_waddr);
    e_txs  = (m_ph == M_REPLY) && tx_rdy;
    check("cycle {we,addr,wdata,cs,txs,txd,led,busy,err}",
          {ram_we, ram_addr, ram_wdata, core_start, tx_start, tx_data, led, busy, err},
          {m_we, e_addr, m_wbit, m_cs, e_txs, m_char, m_char, m_busy, m_err});
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_rdy  = 1'b1;
    rx_data = b;
    tick();
    rx_rdy  = 1'b0;
  endtask

  task automatic send_pixels(input int n, input bit raw);
    for (int i = 0; i < n; i++) begin
      rx_rdy  = 1'b1;
      rx_data = raw ? {7'h00, i[0]} : {7'h18, i[0]};
      tick();
    end
    rx_rdy = 1'b0;
  endtask

  // Called right after the last pixel's rx_rdy cycle.
  task automatic finish_frame(input string tag);
    check({tag, " last we"}, 32'(ram_we), 1);
    check({tag, " last addr"}, 32'(ram_addr), NP - 1);
    check({tag, " start t+1"}, 32'(core_start), 0);
    tick();
    check({tag, " start t+2"}, 32'(core_start), 1);
    check({tag, " busy t+2"}, 32'(busy), 1);
    tick();
    check({tag, " start t+3"}, 32'(core_start), 0);
  endtask

  task automatic sweep_core_addr();
    for (int a = 0; a < NP; a++) begin
      core_addr = a[AW-1:0];
      tick();
      check("compute no write", 32'(ram_we), 0);
    end
  endtask

  task automatic pulse_done(input logic [3:0] d);
    core_digit = d;
    core_done  = 1'b1;
    tick();
    core_done  = 1'b0;
  endtask

  task automatic check_reset_outs();
    check("rst ram_we", 32'(ram_we), 0);
    check("rst ram_addr", 32'(ram_addr), 0);
    check("rst ram_wdata", 32'(ram_wdata), 0);
    check("rst core_start", 32'(core_start), 0);
    check("rst tx_start", 32'(tx_start), 0);
    check("rst tx_data", 32'(tx_data), 0);
    check("rst led", 32'(led), 0);
    check("rst busy", 32'(busy), 0);
    check("rst err", 32'(err), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset.
    tick(); tick();
    check_reset_outs();
    rst_n = 1'b1;
    tick();

    // Frame A: ASCII '0'/'1', compute sweep, digit 7 with TX ready.
    tx_rdy = 1'b1;
    send_pixels(NP, 1'b0);
    finish_frame("A");
    sweep_core_addr();
    pulse_done(4'd7);
    check("A led", 32'(led), 'h37);
    check("A tx_data", 32'(tx_data), 'h37);
    check("A tx_start c+1", 32'(tx_start), 1);
    check("A busy c+1", 32'(busy), 1);
    tick();
    check("A busy falls", 32'(busy), 0);
    check("A tx_start once", 32'(tx_start), 0);
    check("A err clear", 32'(err), 0);

    // Frame B: raw bytes, bad digit 12, TX held off 50 cycles.
    tx_rdy = 1'b0;
    send_pixels(NP, 1'b1);
    finish_frame("B");
    pulse_done(4'd12);
    check("B led", 32'(led), 'h3F);
    check("B err", 32'(err), 1);
    for (int i = 0; i < 49; i++) tick();
    check("B tx held", 32'(tx_start), 0);
    check("B tx_data held", 32'(tx_data), 'h3F);
    tx_rdy = 1'b1;
    #1;
    check("B tx_start on rdy", 32'(tx_start), 1);
    tick();
    check("B busy falls", 32'(busy), 0);

    // Reset after 400 bytes, then a clean frame.
    send_pixels(400, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outs();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    send_pixels(NP, 1'b0);
    finish_frame("R");

    // Overrun during COMPUTE.
    check("R err before overrun", 32'(err), 0);
    send_byte(8'h31);
    check("overrun no we", 32'(ram_we), 0);
    check("overrun err", 32'(err), 1);
    pulse_done(4'd5);
    check("R led", 32'(led), 'h35);
    tick();
    send_byte(8'h31);
    check("post-TX we", 32'(ram_we), 1);
    check("post-TX addr 0", 32'(ram_addr), 0);
    send_pixels(NP - 1, 1'b1);
    finish_frame("P");
    pulse_done(4'd0);
    check("P led", 32'(led), 'h30);
    tick();

    // Timeout discards a partial frame.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    send_pixels(100, 1'b0);
    for (int i = 0; i < TO - 1; i++) tick();
    check("timeout err not yet", 32'(err), 0);
    tick();
    check("timeout err", 32'(err), 1);
    send_byte(8'h01);
    check("timeout next we", 32'(ram_we), 1);
    check("timeout next addr", 32'(ram_addr), 0);
    check("timeout next wdata", 32'(ram_wdata), 1);
    send_pixels(NP - 1, 1'b1);
    finish_frame("T");
    pulse_done(4'd9);
    check("T led", 32'(led), 'h39);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
